// File: rtl/acc_unit.sv
// acc_unit: 8-bit accumulator/ALU stage fed by the operand mux.
//
// Two pipeline stages with full valid/ready backpressure:
//   p0  operand latch  (vld_p0, op_p0, opnd_p0)
//   p1  execute/result (acc, carry, zero, out_valid)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of accumulator, flags and pipeline
//   in_valid   operand/op presented this cycle
//   in_ready   stage can accept an operand this cycle
//   op         00 LOAD, 01 ADD, 10 SUB, 11 AND
//   operand    WIDTH-bit operand
//   acc        registered accumulator
//   carry      carry-out of ADD / borrow of SUB
//   zero       1 when acc == 0
//   out_valid  acc/carry/zero hold an unconsumed result
//   out_ready  downstream accepts the result
module acc_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    logic             vld_p0;
    op_e              op_p0;
    logic [WIDTH-1:0] opnd_p0;

    logic             accept;
    logic             exec_fire;
    logic [WIDTH:0]   res;

    // Returns {carry, acc}. The top bit of a WIDTH+1 subtraction is the
    // unsigned borrow, so SUB needs no separate compare.
    function automatic logic [WIDTH:0] alu(input op_e f,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic c_in);
        logic [WIDTH:0] r;
        case (f)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {c_in, a & b};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    // Result register can take a new value when empty or being drained.
    assign exec_fire = vld_p0 & (!out_valid | out_ready);
    assign in_ready  = !clr & (!vld_p0 | exec_fire);
    assign accept    = in_valid & in_ready;
    assign res       = alu(op_p0, acc, opnd_p0, carry);

    // ---- stage p0: operand latch ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (clr) begin
            vld_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0 <= 1'b1;
        end else if (exec_fire) begin
            vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= op_e'(op);
            opnd_p0 <= operand;
        end
    end

    // ---- stage p1: execute / result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else if (exec_fire) begin
            acc       <= res[WIDTH-1:0];
            carry     <= res[WIDTH];
            zero      <= (res[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed test-plan steps followed by a randomized phase
// scored against a transaction-level accumulator model.
module tb_acc_unit;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] operand;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
    logic       out_valid;
    logic       out_ready;

    int tests = 0;
    int fails = 0;

    logic [1:0] s_op  [32];
    logic [7:0] s_d   [32];
    logic [7:0] e_acc [32];
    logic       e_c   [32];
    logic       e_z   [32];

    int         m_acc;
    int         m_c;
    logic [8:0] q[$];
    logic [8:0] exp_r;

    acc_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] o, input logic [7:0] d);
        in_valid = 1'b1;
        op       = o;
        operand  = d;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] a, input logic c, input logic z);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".acc"},   acc,       a);
        check({tag, ".carry"}, carry,     c);
        check({tag, ".zero"},  zero,      z);
    endtask

    // Issue n ops back to back with out_ready=1; each result must appear
    // exactly one cycle after its acceptance edge.
    task automatic run_seq(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            send(s_op[i], s_d[i]);
            #1;
            check($sformatf("%s.in_ready%0d", tag, i), in_ready, 1);
            step();
            if (i == 0) check({tag, ".latency"}, out_valid, 0);
            else        expect_out($sformatf("%s[%0d]", tag, i - 1), e_acc[i-1], e_c[i-1], e_z[i-1]);
        end
        in_valid = 1'b0;
        step();
        expect_out($sformatf("%s[%0d]", tag, n - 1), e_acc[n-1], e_c[n-1], e_z[n-1]);
        step();
        check({tag, ".drained"}, out_valid, 0);
    endtask

    task automatic set_step(input int i, input logic [1:0] o, input logic [7:0] d,
                            input logic [7:0] a, input logic c, input logic z);
        s_op[i] = o; s_d[i] = d; e_acc[i] = a; e_c[i] = c; e_z[i] = z;
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; op = 2'b00; operand = 8'h00; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst.acc", acc, 0);
        check("rst.carry", carry, 0);
        check("rst.zero", zero, 1);
        check("rst.out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst.in_ready", in_ready, 1);

        // Arithmetic chain
        set_step(0, 2'b00, 8'h33, 8'h33, 0, 0);
        set_step(1, 2'b01, 8'h43, 8'h76, 0, 0);
        set_step(2, 2'b01, 8'hAD, 8'h23, 1, 0);
        set_step(3, 2'b10, 8'hAF, 8'h74, 1, 0);
        set_step(4, 2'b11, 8'h43, 8'h40, 1, 0);
        run_seq("chain", 5);

        // Zero flag
        set_step(0, 2'b00, 8'h43, 8'h43, 0, 0);
        set_step(1, 2'b10, 8'h43, 8'h00, 0, 1);
        set_step(2, 2'b01, 8'hFF, 8'hFF, 0, 0);
        run_seq("zero", 3);

        // Backpressure
        out_ready = 1'b0;
        send(2'b00, 8'h33);
        #1 check("bp.rdy0", in_ready, 1);
        step();
        send(2'b01, 8'h43);
        #1 check("bp.rdy1", in_ready, 1);
        step();
        send(2'b01, 8'hAD);
        #1 check("bp.full", in_ready, 0);
        expect_out("bp.first", 8'h33, 0, 0);
        step();
        check("bp.hold.acc", acc, 8'h33);
        check("bp.hold.rdy", in_ready, 0);
        out_ready = 1'b1;
        #1 check("bp.release", in_ready, 1);
        step();
        in_valid = 1'b0;
        expect_out("bp.second", 8'h76, 0, 0);
        step();
        expect_out("bp.third", 8'h23, 1, 0);
        step();
        check("bp.empty", out_valid, 0);

        // Synchronous clear with an operand offered
        out_ready = 1'b0;
        send(2'b00, 8'h11);
        step();
        clr = 1'b1;
        send(2'b00, 8'hAF);
        #1 check("clr.in_ready", in_ready, 0);
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr.acc", acc, 0);
        check("clr.zero", zero, 1);
        check("clr.carry", carry, 0);
        check("clr.out_valid", out_valid, 0);
        #1 check("clr.latch_empty", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("clr.no_exec", out_valid, 0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        send(2'b00, 8'h55);
        step();
        send(2'b01, 8'h01);
        step();
        in_valid = 1'b0;
        check("arst.pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.acc", acc, 0);
        check("arst.zero", zero, 1);
        check("arst.carry", carry, 0);
        check("arst.out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_step(0, 2'b00, 8'hAD, 8'hAD, 0, 0);
        run_seq("arst.load", 1);

        // Throughput: LOAD 0 then 16 x ADD 1
        set_step(0, 2'b00, 8'h00, 8'h00, 0, 1);
        for (int i = 1; i <= 16; i++) set_step(i, 2'b01, 8'h01, 8'(i), 0, 0);
        run_seq("thru", 17);

        // Randomized traffic against the accumulator model
        m_acc = 'h10;
        m_c   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            op        = 2'($urandom_range(0, 3));
            operand   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                check("rnd.pending", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_r = q.pop_front();
                    check("rnd.acc", acc, exp_r[7:0]);
                    check("rnd.carry", carry, exp_r[8]);
                    check("rnd.zero", zero, (exp_r[7:0] == 8'h00));
                end
            end
            if (in_valid && in_ready) begin
                case (op)
                    2'b00: begin m_acc = operand; m_c = 0; end
                    2'b01: begin
                        m_acc = m_acc + operand;
                        m_c   = (m_acc > 255) ? 1 : 0;
                        m_acc = m_acc % 256;
                    end
                    2'b10: begin
                        m_c   = (m_acc < operand) ? 1 : 0;
                        m_acc = (m_acc - operand + 256) % 256;
                    end
                    default: m_acc = m_acc & operand;
                endcase
                q.push_back({1'(m_c), 8'(m_acc)});
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) begin
                check("drain.pending", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_r = q.pop_front();
                    check("drain.acc", acc, exp_r[7:0]);
                    check("drain.carry", carry, exp_r[8]);
                end
            end
            step();
        end
        check("drain.queue", q.size(), 0);
        check("drain.out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
